// File: rtl/minmax_pkg.sv
// Shared types and sizing helpers for the min/max reduction tree.
// Latency: n/a (package only).
// Backpressure: n/a.
package minmax_pkg;

   typedef enum logic {MODE_MIN = 1'b0, MODE_MAX = 1'b1} mm_mode_e;

   // Number of elements left after one pairwise reduction level: ceil(n/2).
   function automatic int level_count(input int n);
      return (n + 1) / 2;
   endfunction

   // Number of elements entering reduction level s of a tree fed with n leaves.
   function automatic int count_at(input int n, input int s);
      int c;
      c = n;
      for (int i = 0; i < s; i++) begin
         c = level_count(c);
      end
      return c;
   endfunction

endpackage

// File: rtl/minmax_cmp2.sv
// Two-input min/max node: picks the extreme (value, idx) pair, lower index wins ties.
// Latency: combinational.
// Backpressure: none (pure logic).
module minmax_cmp2
   import minmax_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int IDX_W  = 2,
   parameter int SIGNED = 0
) (
   input  logic [WIDTH-1:0] a_value,
   input  logic [IDX_W-1:0] a_idx,
   input  logic [WIDTH-1:0] b_value,
   input  logic [IDX_W-1:0] b_idx,
   input  mm_mode_e         mode,
   output logic [WIDTH-1:0] win_value,
   output logic [IDX_W-1:0] win_idx
);

   logic b_less;
   logic b_greater;
   logic pick_b;

   // Strict compare in the configured number system; equal values fall back to the index.
   always_comb begin
      b_less    = 1'b0;
      b_greater = 1'b0;
      pick_b    = 1'b0;
      if (SIGNED != 0) begin
         b_less    = ($signed(b_value) < $signed(a_value));
         b_greater = ($signed(b_value) > $signed(a_value));
      end else begin
         b_less    = (b_value < a_value);
         b_greater = (b_value > a_value);
      end
      if (b_value == a_value) begin
         pick_b = (b_idx < a_idx);
      end else if (mode == MODE_MAX) begin
         pick_b = b_greater;
      end else begin
         pick_b = b_less;
      end
      win_value = pick_b ? b_value : a_value;
      win_idx   = pick_b ? b_idx   : a_idx;
   end

endmodule

// File: rtl/minmax_tree_pipe.sv
// Pipelined N_CH-way min/max reduction returning the winning value and its channel index.
// Latency: $clog2(N_CH) cycles from accept to out_valid when not stalled.
// Backpressure: global stall, every stage holds while out_valid && !out_ready; in_ready mirrors advance.
module minmax_tree_pipe
   import minmax_pkg::*;
#(
   parameter  int N_CH   = 4,
   parameter  int WIDTH  = 8,
   parameter  int SIGNED = 0,
   localparam int IDX_W  = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_mode,
   input  logic [N_CH*WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_value,
   output logic [IDX_W-1:0]      out_idx
);

   localparam int LEVELS = $clog2(N_CH);

   logic advance;

   for (genvar s = 0; s < LEVELS; s++) begin : g_lvl
      localparam int N_IN  = count_at(N_CH, s);
      localparam int N_OUT = level_count(N_IN);

      logic [WIDTH-1:0] cur_value [N_IN];
      logic [IDX_W-1:0] cur_idx   [N_IN];
      logic             cur_valid;
      mm_mode_e         cur_mode;

      logic [WIDTH-1:0] nxt_value [N_OUT];
      logic [IDX_W-1:0] nxt_idx   [N_OUT];

      logic [WIDTH-1:0] value_q   [N_OUT];
      logic [IDX_W-1:0] idx_q     [N_OUT];
      logic             valid_q;

      // Level inputs: raw channels with their own numbers at level 0, else the previous level's registers.
      if (s == 0) begin : g_src
         for (genvar k = 0; k < N_IN; k++) begin : g_ch
            assign cur_value[k] = in_data[k*WIDTH +: WIDTH];
            assign cur_idx[k]   = IDX_W'(k);
         end
         assign cur_valid = in_valid;
         assign cur_mode  = mm_mode_e'(in_mode);
      end else begin : g_src
         for (genvar k = 0; k < N_IN; k++) begin : g_ch
            assign cur_value[k] = g_lvl[s-1].value_q[k];
            assign cur_idx[k]   = g_lvl[s-1].idx_q[k];
         end
         assign cur_valid = g_lvl[s-1].valid_q;
         assign cur_mode  = g_lvl[s-1].g_mode.mode_q;
      end

      for (genvar p = 0; p < N_IN / 2; p++) begin : g_node
         minmax_cmp2 #(
            .WIDTH  (WIDTH),
            .IDX_W  (IDX_W),
            .SIGNED (SIGNED)
         ) u_cmp (
            .a_value   (cur_value[2*p]),
            .a_idx     (cur_idx[2*p]),
            .b_value   (cur_value[2*p+1]),
            .b_idx     (cur_idx[2*p+1]),
            .mode      (cur_mode),
            .win_value (nxt_value[p]),
            .win_idx   (nxt_idx[p])
         );
      end

      // An unpaired last element rides through untouched, keeping its original channel number.
      if ((N_IN % 2) == 1) begin : g_pass
         assign nxt_value[N_OUT-1] = cur_value[N_IN-1];
         assign nxt_idx[N_OUT-1]   = cur_idx[N_IN-1];
      end

      // Level register: clears on reset, loads on advance, holds during a stall.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
               value_q[k] <= '0;
               idx_q[k]   <= '0;
            end
         end else if (advance) begin
            valid_q <= cur_valid;
            for (int k = 0; k < N_OUT; k++) begin
               value_q[k] <= nxt_value[k];
               idx_q[k]   <= nxt_idx[k];
            end
         end
      end

      // The mode bit travels with the beat; the final level has nothing left to compare so it drops it.
      if (s < LEVELS - 1) begin : g_mode
         mm_mode_e mode_q;

         // Mode register follows the same load/hold rule as the data.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mode_q <= MODE_MIN;
            end else if (advance) begin
               mode_q <= cur_mode;
            end
         end
      end
   end

   assign out_valid = g_lvl[LEVELS-1].valid_q;
   assign out_value = g_lvl[LEVELS-1].value_q[0];
   assign out_idx   = g_lvl[LEVELS-1].idx_q[0];

   // Whole pipe moves together whenever the output slot is empty or being drained.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

endmodule

// File: tb/tb_minmax_tree_pipe.sv
// Directed bench for minmax_tree_pipe: 4-ch unsigned, 4-ch signed and 5-ch instances.
// Latency: checks the 2-cycle and 3-cycle results against hand-computed values.
// Backpressure: stalls the 4-ch pipe and checks hold, in_ready and ordered drain.
module tb_minmax_tree_pipe;

   logic        clk;
   logic        rst_n;

   // Shared stimulus for the 4-channel unsigned and signed instances.
   logic        in_valid;
   logic        in_mode;
   logic [31:0] in_data;
   logic        out_ready;

   logic        in_ready_u, out_valid_u;
   logic [7:0]  out_value_u;
   logic [1:0]  out_idx_u;

   logic        in_ready_s, out_valid_s;
   logic [7:0]  out_value_s;
   logic [1:0]  out_idx_s;

   // 5-channel instance.
   logic        in_valid5;
   logic        in_mode5;
   logic [39:0] in_data5;
   logic        out_ready5;
   logic        in_ready5, out_valid5;
   logic [7:0]  out_value5;
   logic [2:0]  out_idx5;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] V1 = 32'h04030201;
   localparam logic [31:0] V2 = 32'h04131211;
   localparam logic [31:0] V3 = 32'h14131211;
   localparam logic [31:0] VT = 32'h05050505;
   localparam logic [31:0] V7 = 32'h07030309;
   localparam logic [31:0] VS = 32'h7F8000FF;
   localparam logic [39:0] V5 = 40'h0009090901;

   minmax_tree_pipe #(.N_CH(4), .WIDTH(8), .SIGNED(0)) u_dut_u (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_u),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid_u),
      .out_ready (out_ready),
      .out_value (out_value_u),
      .out_idx   (out_idx_u)
   );

   minmax_tree_pipe #(.N_CH(4), .WIDTH(8), .SIGNED(1)) u_dut_s (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_s),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid_s),
      .out_ready (out_ready),
      .out_value (out_value_s),
      .out_idx   (out_idx_s)
   );

   minmax_tree_pipe #(.N_CH(5), .WIDTH(8), .SIGNED(0)) u_dut_5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid5),
      .in_ready  (in_ready5),
      .in_mode   (in_mode5),
      .in_data   (in_data5),
      .out_valid (out_valid5),
      .out_ready (out_ready5),
      .out_value (out_value5),
      .out_idx   (out_idx5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic m, input logic [31:0] d);
      in_valid = v;
      in_mode  = m;
      in_data  = d;
   endtask

   task automatic res_u(input string tag, input logic [7:0] val, input logic [1:0] idx);
      check({tag, "_vld"}, 64'(out_valid_u), 64'd1);
      check({tag, "_val"}, 64'(out_value_u), 64'(val));
      check({tag, "_idx"}, 64'(out_idx_u),   64'(idx));
   endtask

   task automatic res_s(input string tag, input logic [7:0] val, input logic [1:0] idx);
      check({tag, "_vld"}, 64'(out_valid_s), 64'd1);
      check({tag, "_val"}, 64'(out_value_s), 64'(val));
      check({tag, "_idx"}, 64'(out_idx_s),   64'(idx));
   endtask

   task automatic res_5(input string tag, input logic [7:0] val, input logic [2:0] idx);
      check({tag, "_vld"}, 64'(out_valid5), 64'd1);
      check({tag, "_val"}, 64'(out_value5), 64'(val));
      check({tag, "_idx"}, 64'(out_idx5),   64'(idx));
   endtask

   // Linear directed sequence; every wait is a fixed number of clock edges.
   initial begin
      rst_n      = 1'b0;
      drive(1'b0, 1'b0, 32'h0);
      out_ready  = 1'b1;
      in_valid5  = 1'b0;
      in_mode5   = 1'b0;
      in_data5   = 40'h0;
      out_ready5 = 1'b1;

      #12;
      check("rst_out_valid", 64'(out_valid_u), 64'd0);
      check("rst_out_value", 64'(out_value_u), 64'd0);
      check("rst_out_idx",   64'(out_idx_u),   64'd0);
      check("rst_out_valid5", 64'(out_valid5), 64'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready",  64'(in_ready_u), 64'd1);
      check("post_rst_in_ready5", 64'(in_ready5),  64'd1);

      // Min stream, max stream, alternating modes, ties and signedness, back to back.
      drive(1'b1, 1'b0, V1); tick();
      check("lat2_not_yet", 64'(out_valid_u), 64'd0);
      drive(1'b1, 1'b0, V2); tick(); res_u("min_v1", 8'h01, 2'd0);
      drive(1'b1, 1'b0, V3); tick(); res_u("min_v2", 8'h04, 2'd3);
      drive(1'b1, 1'b1, V1); tick(); res_u("min_v3", 8'h11, 2'd0);
      drive(1'b1, 1'b1, V2); tick(); res_u("max_v1", 8'h04, 2'd3);
      drive(1'b1, 1'b1, V3); tick(); res_u("max_v2", 8'h13, 2'd2);
      drive(1'b1, 1'b0, V1); tick(); res_u("max_v3", 8'h14, 2'd3);
      drive(1'b1, 1'b1, V2); tick(); res_u("alt_min_v1", 8'h01, 2'd0);
      drive(1'b1, 1'b0, V3); tick(); res_u("alt_max_v2", 8'h13, 2'd2);
      drive(1'b1, 1'b0, VT); tick(); res_u("alt_min_v3", 8'h11, 2'd0);
      drive(1'b1, 1'b1, VT); tick(); res_u("tie_min", 8'h05, 2'd0);
      drive(1'b1, 1'b0, V7); tick(); res_u("tie_max", 8'h05, 2'd0);
      drive(1'b1, 1'b0, VS); tick(); res_u("tie_min_pair", 8'h03, 2'd1);
      drive(1'b1, 1'b1, VS); tick();
      res_u("uns_min", 8'h00, 2'd1);
      res_s("sgn_min", 8'h80, 2'd2);
      drive(1'b0, 1'b0, 32'h0); tick();
      res_u("uns_max", 8'hFF, 2'd0);
      res_s("sgn_max", 8'h7F, 2'd3);
      tick();
      check("bubble_out_valid",   64'(out_valid_u), 64'd0);
      check("bubble_out_valid_s", 64'(out_valid_s), 64'd0);

      // Backpressure: stall with the second result showing, then drain.
      drive(1'b1, 1'b0, V1); tick();
      drive(1'b1, 1'b0, V2); tick(); res_u("bp_b1", 8'h01, 2'd0);
      drive(1'b1, 1'b0, V3); tick(); res_u("bp_b2", 8'h04, 2'd3);
      out_ready = 1'b0;
      drive(1'b1, 1'b0, VT);
      #1;
      check("bp_in_ready_low", 64'(in_ready_u), 64'd0);
      check("bp_in_ready_low_s", 64'(in_ready_s), 64'd0);
      tick(); res_u("bp_hold1", 8'h04, 2'd3);
      check("bp_in_ready_hold", 64'(in_ready_u), 64'd0);
      tick(); res_u("bp_hold2", 8'h04, 2'd3);
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_release", 64'(in_ready_u), 64'd1);
      tick(); res_u("bp_b3", 8'h11, 2'd0);
      drive(1'b0, 1'b0, 32'h0); tick(); res_u("bp_b4", 8'h05, 2'd0);
      tick();
      check("bp_no_dup", 64'(out_valid_u), 64'd0);

      // Five channels: odd count at level 0 and level 1, 3-cycle latency.
      in_valid5 = 1'b1; in_mode5 = 1'b0; in_data5 = V5; tick();
      in_mode5 = 1'b1; tick();
      check("lat3_not_yet", 64'(out_valid5), 64'd0);
      in_mode5 = 1'b0; tick(); res_5("n5_min", 8'h00, 3'd4);
      tick(); res_5("n5_max", 8'h09, 3'd1);

      // Asynchronous reset mid-stream, away from the clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid5", 64'(out_valid5), 64'd0);
      check("arst_out_value5", 64'(out_value5), 64'd0);
      check("arst_out_idx5",   64'(out_idx5),   64'd0);
      in_valid5 = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("arst_in_ready5", 64'(in_ready5), 64'd1);
      tick();
      check("arst_no_stale1", 64'(out_valid5), 64'd0);
      tick();
      tick();
      check("arst_no_stale2", 64'(out_valid5), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
